// File: rtl/mux4x1_arbiter_if.sv
// Request/grant bundle between the four requesters and the 4:1 mux arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface mux4x1_arbiter_if;
  logic [3:0] R;
  logic       Done;
  logic       S1;
  logic       S0;
  logic [3:0] G;
  logic       Valid;
  logic       Timeout;

  modport master (
    output R, Done,
    input  S1, S0, G, Valid, Timeout
  );

  modport slave (
    input  R, Done,
    output S1, S0, G, Valid, Timeout
  );
endinterface

// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select lines, with a per-grant hold
// limit so one requester cannot monopolise the shared output line.
module mux4x1_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  mux4x1_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      g_q, g_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic            rel_done, rel_drop, rel_limit;
  logic [3:0]      req_m;
  logic [2:0]      pick;

  // Search last+1, last+2, last+3, last; the previous owner ranks lowest.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      g_q       <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      g_q       <= g_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    g_d       = g_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    rel_done  = 1'b0;
    rel_drop  = 1'b0;
    rel_limit = 1'b0;
    req_m     = bus.R;
    pick      = 3'b000;

    case (state_q)
      IDLE: begin
        pick = rr_pick(bus.R, last_q);
        if (pick[2]) begin
          sel_d   = pick[1:0];
          g_d     = 4'b0001 << pick[1:0];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          g_d     = 4'b0000;
          valid_d = 1'b0;
        end
      end

      GRANT: begin
        rel_done  = bus.Done;
        rel_drop  = !bus.R[sel_q];
        rel_limit = (cnt_q == CW'(HOLD_MAX - 1));
        if (rel_done || rel_drop || rel_limit) begin
          last_d = sel_q;
          // A voluntary release or drop hides the old owner; a timeout does not.
          if (rel_done || rel_drop) req_m[sel_q] = 1'b0;
          pick      = rr_pick(req_m, sel_q);
          timeout_d = rel_limit && !rel_done && !rel_drop;
          if (pick[2]) begin
            sel_d   = pick[1:0];
            g_d     = 4'b0001 << pick[1:0];
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            g_d     = 4'b0000;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.S1      = sel_q[1];
  assign bus.S0      = sel_q[0];
  assign bus.G       = g_q;
  assign bus.Valid   = valid_q;
  assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Directed bench for mux4x1_arbiter: the driver queues the expected outputs for
// each edge and an independent monitor compares them after that edge.
module tb_mux4x1_arbiter;

  logic Clk = 1'b0;
  logic Rst_n;

  mux4x1_arbiter_if bus();

  mux4x1_arbiter #(.HOLD_MAX(8), .CW(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Outputs settle at the posedge; compare one queued expectation per edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.G !== e.g || {bus.S1, bus.S0} !== e.s ||
          bus.Valid !== e.v || bus.Timeout !== e.t) begin
        errors++;
        $display("FAIL edge%0d got G=%b S=%b V=%b T=%b want G=%b S=%b V=%b T=%b",
                 checks, bus.G, {bus.S1, bus.S0}, bus.Valid, bus.Timeout,
                 e.g, e.s, e.v, e.t);
      end
    end
  end

  task automatic step(input logic rst_n, input logic [3:0] r, input logic done,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic t);
    exp_t e;
    @(negedge Clk);
    Rst_n    = rst_n;
    bus.R    = r;
    bus.Done = done;
    e.g = g; e.s = s; e.v = v; e.t = t;
    exp_q.push_back(e);
  endtask

  initial begin
    Rst_n    = 1'b0;
    bus.R    = 4'b0000;
    bus.Done = 1'b0;

    // Reset state
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    step(0, 4'b0101, 1, 4'b0000, 2'd0, 0, 0);

    // Single requester 0, Done on the third grant cycle
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    // Reset so rotation starts at 0, then all four requesting
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b1111, 1, 4'b0010, 2'd1, 1, 0);
    step(1, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
    step(1, 4'b1111, 1, 4'b0100, 2'd2, 1, 0);
    step(1, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
    step(1, 4'b1111, 1, 4'b1000, 2'd3, 1, 0);
    step(1, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
    step(1, 4'b1111, 1, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    // Sole requester 2 held: timeout every 8 cycles, re-granted with no gap
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 7; i++) step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
    end
    step(1, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

    // Owner 1 drops while requester 0 waits
    step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    step(1, 4'b0011, 0, 4'b0010, 2'd1, 1, 0);
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    // Done coincides with the hold limit: no timeout, one idle cycle
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
    step(1, 4'b1000, 1, 4'b0000, 2'd3, 0, 0);
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);

    // Hand to requester 2, then reset mid-grant
    step(1, 4'b0100, 1, 4'b0100, 2'd2, 1, 0);
    step(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4x1_arbiter.md
# mux4x1_arbiter

Round-robin arbiter and select sequencer for the shared 4:1 mux datapath. Four requesters compete for the single mux output line D. The block grants one requester at a time and drives the mux select lines S1,S0 to that requester's input. Each grant is bounded by a hold-time limit so no requester can starve the others. It sits directly in front of the 4:1 mux: its S1,S0 connect to the mux select inputs and its grant vector goes back to the requesters.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles one grant may last (legal range 1..15).
- CW, 4: width of the hold counter; must satisfy 2^CW > HOLD_MAX.

- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  reset; synchronous and active-low.
- R  input  4  request vector; R[i] high = requester i wants mux input Ii.
- Done  input  1  current owner releases the grant; sampled only in GRANT.
- S1  output  1  mux select MSB (owner index bit 1).
- S0  output  1  mux select LSB (owner index bit 0).
- G  output  4  one-hot grant; G[i] high = requester i owns D.
- Valid  output  1  high while any grant is active; D is meaningful.
- Timeout  output  1  one-cycle pulse after a grant is revoked by the hold limit.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - Last, 2 bits: index of the most recent owner.
  - Cnt, CW bits: hold counter.
- Reset (Rst_n=0 at an edge): FSM=IDLE, S1:S0=00, G=0000, Valid=0, Timeout=0, Last=3, Cnt=0. The first arbitration after reset therefore gives requester 0 top priority.
- Round-robin pick: search indices Last+1, Last+2, Last+3, Last (mod 4). The first index whose R bit is set wins. The previous owner has the lowest priority.
- IDLE:
  - If R=0000: stay in IDLE. G=0000, Valid=0. S1:S0 hold their last value.
  - If R≠0000: pick a winner, load S1:S0=winner, G=onehot(winner), Valid=1, Cnt=0, go to GRANT.
  - Done is ignored in IDLE.
- GRANT: S1:S0 and G stay stable. A release occurs at an edge when any of these holds:
  - (a) Done=1;
  - (b) R[owner]=0, i.e. the requester dropped;
  - (c) Cnt=HOLD_MAX-1, which is a timeout.
- No release: Cnt increments by 1.
- On release:
  - Last <= owner.
  - Re-arbitrate in the same edge, using the updated Last and the current R with R[owner] masked to 0 for reasons (a) and (b).
  - If there is a winner: load the new grant, Cnt=0, stay in GRANT. Handoff has no idle bubble.
  - If there is no winner: go to IDLE, G=0000, Valid=0.
- Timeout (c) leaves R[owner] unmasked, so a sole requester is re-granted immediately with Cnt=0.
- Timeout pulses 1 for the cycle after a release caused only by (c).
- Precedence when release conditions coincide:
  - Done together with the limit counts as Done; Timeout=0.
  - R[owner]=0 together with the limit counts as a drop; Timeout=0.
- Invariants:
  - G is either 0000 or one-hot.
  - Valid = OR of the G bits.
  - When Valid=1, S1:S0 equals the index of the set G bit.

## Timing
- All outputs are registered. There are no combinational paths from R or Done to any output.
- Grant latency: R is sampled at edge k and G/S/Valid are valid from edge k onward, i.e. visible in the cycle after the request is presented.
- Maximum grant length is HOLD_MAX cycles with Valid=1 and the same owner.
- The worst-case wait for a continuously requesting input is 3×HOLD_MAX cycles.
- Reset asserted mid-grant clears all state at that edge, regardless of Done or R. Valid=0 in the following cycle.
- S1:S0 change only at the edge where a new grant is loaded, never while Valid=1 for the same owner.

## Test plan
- Reset, then R=0001 held and Done pulsed at the 3rd grant cycle:
  - G=0001, S=00, Valid=1 one cycle after R rises.
  - Release at the Done edge; G=0000 the next cycle.
- R=1111 held, Done pulsed every 2nd grant cycle:
  - Owners rotate 0,1,2,3,0 with S=00,01,10,11,00.
  - No idle cycle between grants.
- R=0100 held, no Done, HOLD_MAX=8:
  - Valid stays high with S=10.
  - Timeout pulses once every 8 cycles.
  - Requester 2 is re-granted with no gap.
- Owner 1 granted, R=0011, then R[1] drops at cycle 2:
  - Grant passes to requester 0 at that edge.
  - Timeout=0.
- Done=1 and Cnt=HOLD_MAX-1 at the same edge with R=1000 held:
  - Timeout=0.
  - Requester 3 is masked by the Done release, so the arbiter returns to IDLE with G=0000.
  - Requester 3 is re-granted one cycle later.
- Rst_n=0 while G=0100:
  - Next cycle G=0000, Valid=0, S=00.
  - After release of reset with R=1111, the first owner is 0.
